// File: rtl/pipe_step_ctrl_if.sv
// Control/status bundle between the pipeline stepping controller and its host.
// Host drives mode, step, resume and breakpoint setup; controller returns enable and status.
interface pipe_step_ctrl_if #(
    parameter int DIV_W  = 26,
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 2
) ();
    logic [1:0]             Mode;
    logic [DIV_W-1:0]       DivSel;
    logic                   StepBtn;
    logic                   Resume;
    logic [ADDR_W-1:0]      PC;
    logic [NUM_BP-1:0]      BpEn;
    logic [NUM_BP*ADDR_W-1:0] BpAddr;
    logic                   StageEn;
    logic                   Halted;
    logic [NUM_BP-1:0]      BpHit;
    logic [31:0]            CycleCount;

    modport master (
        output Mode, DivSel, StepBtn, Resume, PC, BpEn, BpAddr,
        input  StageEn, Halted, BpHit, CycleCount
    );

    modport slave (
        input  Mode, DivSel, StepBtn, Resume, PC, BpEn, BpAddr,
        output StageEn, Halted, BpHit, CycleCount
    );
endinterface

// File: rtl/pipe_step_ctrl.sv
// Pipeline advance-enable generator: hold / free-run / divided / single-step with PC breakpoints.
// Latency: StageEn is registered, one cycle after the issue decision; step button adds 2 sync flops.
// Backpressure: none; breakpoints suppress issue and park in BREAK until Resume.
module pipe_step_ctrl #(
    parameter int          DIV_W         = 26,
    parameter int          ADDR_W        = 32,
    parameter int          NUM_BP        = 2,
    parameter logic [31:0] CNT_RESET_VAL = 32'd0
) (
    input  logic            Clk,
    input  logic            Rst,
    pipe_step_ctrl_if.slave bus
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_DIV  = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BREAK = 1'b1
    } state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [DIV_W-1:0]   div_cnt;
    logic               sync1;
    logic               sync2;
    logic               step_prev;
    logic               skip;
    logic               stage_en;
    logic               halted;
    logic [NUM_BP-1:0]  bp_hit;
    logic [31:0]        cycle_count;

    logic               mode_chg;
    logic               step_edge;
    logic               due;
    logic               bp_mode;
    logic               bp_stop;
    logic               issue;
    logic [NUM_BP-1:0]  bp_match;

    assign mode_chg  = (bus.Mode != mode_q);
    assign step_edge = sync2 & ~step_prev;

    always_comb begin
        bp_match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_match[i] = bus.BpEn[i] && (bus.PC == bus.BpAddr[i*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        due     = 1'b0;
        bp_mode = 1'b0;
        case (bus.Mode)
            MODE_FREE: begin
                due     = 1'b1;
                bp_mode = 1'b1;
            end
            MODE_DIV: begin
                due     = (div_cnt >= bus.DivSel);
                bp_mode = 1'b1;
            end
            MODE_STEP: due = step_edge;
            default:   due = 1'b0;
        endcase
    end

    // A mode change in the same cycle outranks both issue and breakpoint entry.
    assign bp_stop = due && bp_mode && (|bp_match) && !skip && (state == ST_RUN) && !mode_chg;
    assign issue   = due && (state == ST_RUN) && !mode_chg && !bp_stop;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= ST_RUN;
            mode_q      <= MODE_HOLD;
            div_cnt     <= '0;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            step_prev   <= 1'b0;
            skip        <= 1'b0;
            stage_en    <= 1'b0;
            halted      <= 1'b0;
            bp_hit      <= '0;
            cycle_count <= CNT_RESET_VAL;
        end else begin
            mode_q    <= bus.Mode;
            sync1     <= bus.StepBtn;
            sync2     <= sync1;
            step_prev <= mode_chg ? 1'b0 : sync2;
            stage_en  <= issue;
            halted    <= (state == ST_BREAK) || (bus.Mode == MODE_HOLD);

            if (mode_chg || (bus.Mode != MODE_DIV) || (state == ST_BREAK)) begin
                div_cnt <= '0;
            end else if (due) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            case (state)
                ST_RUN:   if (bp_stop) state <= ST_BREAK;
                ST_BREAK: if (bus.Resume) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase

            // Skip lets the instruction sitting on a breakpoint go through once after Resume.
            if (mode_chg) begin
                skip <= 1'b0;
            end else if ((state == ST_BREAK) && bus.Resume) begin
                skip <= 1'b1;
            end else if (issue) begin
                skip <= 1'b0;
            end

            bp_hit <= (bus.Resume ? '0 : bp_hit) | (bp_stop ? bp_match : '0);

            if (issue && (cycle_count != 32'hFFFF_FFFF)) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    assign bus.StageEn    = stage_en;
    assign bus.Halted     = halted;
    assign bus.BpHit      = bp_hit;
    assign bus.CycleCount = cycle_count;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl: per-cycle vector table plus multi-cycle sequences.
module tb_pipe_step_ctrl;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    pipe_step_ctrl_if #(.DIV_W(26), .ADDR_W(32), .NUM_BP(2)) bus ();
    pipe_step_ctrl_if #(.DIV_W(26), .ADDR_W(32), .NUM_BP(2)) sbus ();

    pipe_step_ctrl #(.DIV_W(26), .ADDR_W(32), .NUM_BP(2)) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus)
    );

    // Second instance preloaded close to the counter ceiling.
    pipe_step_ctrl #(.DIV_W(26), .ADDR_W(32), .NUM_BP(2), .CNT_RESET_VAL(32'hFFFF_FFFD)) dut_sat (
        .Clk(Clk), .Rst(Rst), .bus(sbus)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [25:0] div;
        logic        step;
        logic        resume;
        logic        exp_stage;
        logic        exp_halted;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    bit   pc_auto  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One rising edge, then sample 1ns later; the PC model advances when an enable was issued.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (pc_auto && bus.StageEn) bus.PC = bus.PC + 32'd4;
    endtask

    task automatic add(input logic [1:0] m, input logic [25:0] d, input logic s, input logic r,
                       input logic es, input logic eh, input logic [31:0] ec);
        vec_t v;
        v.mode = m; v.div = d; v.step = s; v.resume = r;
        v.exp_stage = es; v.exp_halted = eh; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int errs;
        int highs;
        logic [31:0] c0;

        bus.Mode = 2'b00; bus.DivSel = '0; bus.StepBtn = 1'b0; bus.Resume = 1'b0;
        bus.PC = '0; bus.BpEn = '0; bus.BpAddr = '0;
        sbus.Mode = 2'b01; sbus.DivSel = '0; sbus.StepBtn = 1'b0; sbus.Resume = 1'b0;
        sbus.PC = '0; sbus.BpEn = '0; sbus.BpAddr = '0;

        //   mode   div    step resume stage halted cnt
        add(2'b00, 26'd0, 0, 0, 0, 1, 0);
        add(2'b01, 26'd0, 0, 0, 0, 0, 0);
        add(2'b01, 26'd0, 0, 0, 1, 0, 1);
        add(2'b01, 26'd0, 0, 0, 1, 0, 2);
        add(2'b10, 26'd1, 0, 0, 0, 0, 2);
        add(2'b10, 26'd1, 0, 0, 0, 0, 2);
        add(2'b10, 26'd1, 0, 0, 1, 0, 3);
        add(2'b10, 26'd1, 0, 0, 0, 0, 3);
        add(2'b10, 26'd1, 0, 0, 1, 0, 4);
        add(2'b10, 26'd0, 0, 0, 1, 0, 5);
        add(2'b10, 26'd0, 0, 0, 1, 0, 6);
        add(2'b00, 26'd0, 0, 0, 0, 1, 6);
        add(2'b00, 26'd0, 0, 0, 0, 1, 6);
        add(2'b11, 26'd0, 0, 0, 0, 0, 6);
        add(2'b11, 26'd0, 1, 0, 0, 0, 6);
        add(2'b11, 26'd0, 1, 0, 0, 0, 6);
        add(2'b11, 26'd0, 1, 0, 1, 0, 7);
        add(2'b11, 26'd0, 1, 0, 0, 0, 7);
        add(2'b11, 26'd0, 0, 0, 0, 0, 7);
        add(2'b11, 26'd0, 0, 0, 0, 0, 7);
        add(2'b11, 26'd0, 1, 0, 0, 0, 7);
        add(2'b11, 26'd0, 1, 0, 0, 0, 7);
        add(2'b11, 26'd0, 1, 0, 1, 0, 8);
        add(2'b01, 26'd0, 1, 0, 0, 0, 8);
        add(2'b01, 26'd0, 0, 1, 1, 0, 9);

        #12;
        chk("rst_stage_en", bus.StageEn, 0);
        chk("rst_halted", bus.Halted, 0);
        chk("rst_bp_hit", bus.BpHit, 0);
        chk("rst_cycle_count", bus.CycleCount, 0);
        chk("rst_sat_preload", sbus.CycleCount, 32'hFFFF_FFFD);
        @(negedge Clk);
        Rst = 1'b1;

        foreach (vecs[i]) begin
            bus.Mode = vecs[i].mode; bus.DivSel = vecs[i].div;
            bus.StepBtn = vecs[i].step; bus.Resume = vecs[i].resume;
            tick();
            chk($sformatf("vec%0d_stage_en", i), bus.StageEn, vecs[i].exp_stage);
            chk($sformatf("vec%0d_halted", i), bus.Halted, vecs[i].exp_halted);
            chk($sformatf("vec%0d_cycle_count", i), bus.CycleCount, vecs[i].exp_cnt);
        end
        bus.Resume = 1'b0; bus.StepBtn = 1'b0;

        // Held step button: one pulse per press, on the third edge after the rise.
        bus.Mode = 2'b11;
        tick();
        c0 = bus.CycleCount;
        errs = 0;
        for (int p = 0; p < 3; p++) begin
            bus.StepBtn = 1'b1;
            for (int k = 1; k <= 50; k++) begin
                tick();
                if (bus.StageEn !== (k == 3)) errs++;
            end
            bus.StepBtn = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (bus.StageEn !== 1'b0) errs++;
            end
        end
        chk("step_hold_pattern", errs, 0);
        chk("step_hold_count", bus.CycleCount - c0, 3);

        // Divide by 4 over 20 cycles.
        bus.Mode = 2'b10; bus.DivSel = 26'd3;
        tick();
        chk("div_mode_change_no_issue", bus.StageEn, 0);
        c0 = bus.CycleCount;
        errs = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.StageEn !== ((k % 4) == 0)) errs++;
        end
        chk("div4_pattern", errs, 0);
        chk("div4_count", bus.CycleCount - c0, 5);

        // Lowering DivSel below the running counter issues on the next cycle.
        bus.Mode = 2'b01;
        tick();
        bus.Mode = 2'b10; bus.DivSel = 26'd100;
        tick();
        highs = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.StageEn) highs++;
        end
        chk("div100_quiet", highs, 0);
        bus.DivSel = 26'd10;
        tick();
        chk("divsel_lower_issue", bus.StageEn, 1);
        errs = 0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (bus.StageEn !== ((k % 11) == 0)) errs++;
        end
        chk("div11_pattern", errs, 0);

        // Breakpoint on 0x10 in free-run, then resume past it.
        bus.Mode = 2'b00;
        tick();
        tick();
        bus.PC = 32'h0; bus.BpEn = 2'b01; bus.BpAddr = {32'h0000_0100, 32'h0000_0010};
        pc_auto = 1'b1;
        bus.Mode = 2'b01;
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.StageEn) highs++;
        end
        chk("bp_issues_before_stop", highs, 4);
        chk("bp_stop_pc", bus.PC, 32'h10);
        chk("bp_stage_en_low", bus.StageEn, 0);
        chk("bp_halted", bus.Halted, 1);
        chk("bp_hit", bus.BpHit, 2'b01);
        bus.Resume = 1'b1;
        tick();
        bus.Resume = 1'b0;
        chk("resume_clears_bp_hit", bus.BpHit, 2'b00);
        chk("resume_edge_no_issue", bus.StageEn, 0);
        tick();
        chk("resume_issue_at_bp", bus.StageEn, 1);
        chk("resume_pc_advanced", bus.PC, 32'h14);
        tick();
        chk("resume_continues", bus.StageEn, 1);
        chk("resume_halted_low", bus.Halted, 0);

        // Single-step over a matching PC is never suppressed.
        pc_auto = 1'b0;
        bus.PC = 32'h10;
        bus.Mode = 2'b11;
        tick();
        bus.StepBtn = 1'b1;
        tick();
        tick();
        tick();
        chk("step_over_bp_issue", bus.StageEn, 1);
        chk("step_over_bp_no_hit", bus.BpHit, 2'b00);
        bus.StepBtn = 1'b0;
        tick();
        tick();

        // Reset asserted while parked in BREAK on comparator 1.
        bus.BpEn = 2'b10; bus.BpAddr = {32'h0000_0040, 32'h0000_0010}; bus.PC = 32'h40;
        bus.Mode = 2'b01;
        for (int k = 0; k < 4; k++) tick();
        chk("bp1_hit", bus.BpHit, 2'b10);
        chk("bp1_halted", bus.Halted, 1);
        #2;
        Rst = 1'b0;
        #1;
        chk("async_rst_stage_en", bus.StageEn, 0);
        chk("async_rst_halted", bus.Halted, 0);
        chk("async_rst_bp_hit", bus.BpHit, 0);
        chk("async_rst_cycle_count", bus.CycleCount, 0);
        bus.BpEn = 2'b00;
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        chk("post_rst_edge1_stage_en", bus.StageEn, 0);
        tick();
        chk("post_rst_edge2_stage_en", bus.StageEn, 1);
        chk("post_rst_cycle_count", bus.CycleCount, 1);

        for (int k = 0; k < 6; k++) tick();
        chk("sat_cycle_count", sbus.CycleCount, 32'hFFFF_FFFF);
        chk("sat_still_issuing", sbus.StageEn, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
